// File: rtl/ulpi_reg_scheduler.sv
// ulpi_reg_scheduler: round-robin sharing of the ULPI PHY register port among N_REQ requesters,
// one op in flight, bounded retry on REG_FAIL, timeout watchdog. Optional macro: ULPI_INIT_SEQ_EN.
module ulpi_reg_scheduler #(
    parameter int N_REQ     = 2,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 255
) (
    input  logic               i_clk_60m,
    input  logic               i_rst_usb,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [N_REQ-1:0]   i_req_rw,
    input  logic [6*N_REQ-1:0] i_req_addr,
    input  logic [8*N_REQ-1:0] i_req_wdata,
    output logic [N_REQ-1:0]   o_gnt_done,
    output logic [N_REQ-1:0]   o_gnt_fail,
    output logic [7:0]         o_rdata,
    output logic               o_busy,
    input  logic               i_ulpi_ready,
    output logic               o_reg_en,
    output logic               o_reg_rw,
    output logic [5:0]         o_reg_addr,
    output logic [7:0]         o_reg_data_i,
    input  logic [7:0]         i_reg_data_o,
    input  logic               i_reg_done,
`ifdef ULPI_INIT_SEQ_EN
    output logic               o_init_done,
    output logic               o_init_err,
`endif
    input  logic               i_reg_fail
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_GAP   = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;

    logic [2:0]       r_state;
    logic [2:0]       r_rr;
    logic [2:0]       r_gnt;
    logic [7:0]       r_retry;
    logic [7:0]       r_tmo;
    logic             r_gap;
    logic             r_reg_en;
    logic             r_reg_rw;
    logic [5:0]       r_reg_addr;
    logic [7:0]       r_reg_data_i;
    logic [7:0]       r_rdata;
    logic             r_busy;
    logic [N_REQ-1:0] r_gnt_done;
    logic [N_REQ-1:0] r_gnt_fail;

    logic [3:0]       w_pick;
    logic             w_win_rw;
    logic [5:0]       w_win_addr;
    logic [7:0]       w_win_wdata;
    logic             w_grant;
    logic             w_op_done;
    logic             w_fail_retry;
    logic             w_op_abort;
    logic             w_can_retry;
    logic [N_REQ-1:0] w_gnt_onehot;
    logic [2:0]       w_rr_next;
    logic             w_init_pend;
    logic [5:0]       w_init_addr;
    logic [7:0]       w_init_data;
    logic             w_op_is_init;

    // Returns {found, index} of the first set request at or after ptr, wrapping at N_REQ.
    function automatic logic [3:0] rr_pick(input logic [N_REQ-1:0] req, input logic [2:0] ptr);
        logic [3:0] res;
        int         idx;
        res = 4'd0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!res[3] && req[idx]) begin
                res = {1'b1, 3'(idx)};
            end
        end
        return res;
    endfunction

    assign w_pick = rr_pick(i_req, r_rr);

    // Field mux for the round-robin winner.
    always_comb begin
        w_win_rw    = 1'b0;
        w_win_addr  = 6'd0;
        w_win_wdata = 8'd0;
        for (int i = 0; i < N_REQ; i++) begin
            w_win_rw    = (w_pick[2:0] == 3'(i)) ? i_req_rw[i]          : w_win_rw;
            w_win_addr  = (w_pick[2:0] == 3'(i)) ? i_req_addr[6*i +: 6]  : w_win_addr;
            w_win_wdata = (w_pick[2:0] == 3'(i)) ? i_req_wdata[8*i +: 8] : w_win_wdata;
        end
    end

    assign w_grant      = (r_state == ST_IDLE) && i_ulpi_ready && (w_init_pend || w_pick[3]);
    assign w_can_retry  = (r_retry < 8'(MAX_RETRY));
    assign w_op_done    = (r_state == ST_WAIT) && i_reg_done;
    assign w_fail_retry = (r_state == ST_WAIT) && !i_reg_done && i_reg_fail && w_can_retry;
    // r_tmo holds cycles elapsed since the REG_EN cycle, so firing at TIMEOUT-1 puts the
    // GNT_FAIL pulse exactly TIMEOUT cycles after REG_EN (TIMEOUT must be >= 2).
    assign w_op_abort   = (r_state == ST_WAIT) && !i_reg_done &&
                          ((i_reg_fail && !w_can_retry) ||
                           (!i_reg_fail && (r_tmo == 8'(TIMEOUT - 1))));
    assign w_gnt_onehot = N_REQ'(1'b1) << r_gnt;
    assign w_rr_next    = (r_gnt == 3'(N_REQ - 1)) ? 3'd0 : (r_gnt + 3'd1);

`ifdef ULPI_INIT_SEQ_EN
    logic r_init_op;
    logic r_init_step;
    logic r_init_done;
    logic r_init_err;

    assign w_init_pend  = !r_init_done;
    assign w_init_addr  = r_init_step ? 6'h0A : 6'h04;
    assign w_init_data  = r_init_step ? 8'h00 : 8'h45;
    assign w_op_is_init = r_init_op;

    // Init sequence progress: FUNC_CTRL then OTG_CTRL; any failure ends the sequence with an error.
    always_ff @(posedge i_clk_60m) begin
        if (i_rst_usb) begin
            r_init_op   <= 1'b0;
            r_init_step <= 1'b0;
            r_init_done <= 1'b0;
            r_init_err  <= 1'b0;
        end else begin
            if (w_grant && w_init_pend) begin
                r_init_op <= 1'b1;
            end else if (r_state == ST_RESP) begin
                r_init_op <= 1'b0;
            end else begin
                r_init_op <= r_init_op;
            end
            if (r_init_op && w_op_done) begin
                r_init_step <= 1'b1;
                r_init_done <= r_init_step;
            end else if (r_init_op && w_op_abort) begin
                r_init_done <= 1'b1;
                r_init_err  <= 1'b1;
            end else begin
                r_init_step <= r_init_step;
                r_init_done <= r_init_done;
            end
        end
    end

    assign o_init_done = r_init_done;
    assign o_init_err  = r_init_err;
`else
    assign w_init_pend  = 1'b0;
    assign w_init_addr  = 6'd0;
    assign w_init_data  = 8'd0;
    assign w_op_is_init = 1'b0;
`endif

    // Main scheduler FSM; response pulses and REG_EN default low every cycle.
    always_ff @(posedge i_clk_60m) begin
        if (i_rst_usb) begin
            r_state      <= ST_IDLE;
            r_rr         <= 3'd0;
            r_gnt        <= 3'd0;
            r_retry      <= 8'd0;
            r_tmo        <= 8'd0;
            r_gap        <= 1'b0;
            r_reg_en     <= 1'b0;
            r_reg_rw     <= 1'b0;
            r_reg_addr   <= 6'd0;
            r_reg_data_i <= 8'd0;
            r_rdata      <= 8'd0;
            r_busy       <= 1'b0;
            r_gnt_done   <= {N_REQ{1'b0}};
            r_gnt_fail   <= {N_REQ{1'b0}};
        end else begin
            r_reg_en   <= 1'b0;
            r_gnt_done <= {N_REQ{1'b0}};
            r_gnt_fail <= {N_REQ{1'b0}};
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_state  <= ST_ISSUE;
                        r_reg_en <= 1'b1;
                        r_busy   <= 1'b1;
                        if (w_init_pend) begin
                            r_reg_rw     <= 1'b1;
                            r_reg_addr   <= w_init_addr;
                            r_reg_data_i <= w_init_data;
                        end else begin
                            r_reg_rw     <= w_win_rw;
                            r_reg_addr   <= w_win_addr;
                            r_reg_data_i <= w_win_wdata;
                            r_gnt        <= w_pick[2:0];
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    r_tmo   <= 8'd1;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_op_done) begin
                        if (!r_reg_rw) begin
                            r_rdata <= i_reg_data_o;
                        end else begin
                            r_rdata <= r_rdata;
                        end
                        if (!w_op_is_init) begin
                            r_gnt_done <= w_gnt_onehot;
                        end else begin
                            r_gnt_done <= {N_REQ{1'b0}};
                        end
                        r_busy  <= 1'b0;
                        r_state <= ST_RESP;
                    end else if (w_fail_retry) begin
                        r_retry <= r_retry + 8'd1;
                        r_gap   <= 1'b0;
                        r_state <= ST_GAP;
                    end else if (w_op_abort) begin
                        if (!w_op_is_init) begin
                            r_gnt_fail <= w_gnt_onehot;
                        end else begin
                            r_gnt_fail <= {N_REQ{1'b0}};
                        end
                        r_busy  <= 1'b0;
                        r_state <= ST_RESP;
                    end else begin
                        r_tmo <= r_tmo + 8'd1;
                    end
                end
                ST_GAP: begin
                    // Two idle cycles let the ULPI wrapper drop its latched request before re-issue.
                    if (r_gap && i_ulpi_ready) begin
                        r_state  <= ST_ISSUE;
                        r_reg_en <= 1'b1;
                    end else begin
                        r_gap <= 1'b1;
                    end
                end
                ST_RESP: begin
                    r_retry <= 8'd0;
                    if (!w_op_is_init) begin
                        r_rr <= w_rr_next;
                    end else begin
                        r_rr <= r_rr;
                    end
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_gnt_done   = r_gnt_done;
    assign o_gnt_fail   = r_gnt_fail;
    assign o_rdata      = r_rdata;
    assign o_busy       = r_busy;
    assign o_reg_en     = r_reg_en;
    assign o_reg_rw     = r_reg_rw;
    assign o_reg_addr   = r_reg_addr;
    assign o_reg_data_i = r_reg_data_i;

endmodule

// File: tb/tb_ulpi_reg_scheduler.sv
// Self-checking bench for ulpi_reg_scheduler: PHY register-port model, table-driven single ops,
// plus fairness, timeout, READY-low, reset-mid-op and (with ULPI_INIT_SEQ_EN) init sequence checks.
module tb_ulpi_reg_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [1:0]  req_rw = 2'b00;
    logic [11:0] req_addr = 12'h000;
    logic [15:0] req_wdata = 16'h0000;
    logic        ready = 1'b1;
    logic [7:0]  reg_data_o = 8'h00;
    logic        reg_done = 1'b0;
    logic        reg_fail = 1'b0;
    logic [1:0]  gnt_done, gnt_fail;
    logic [7:0]  rdata, reg_data_i;
    logic        busy, reg_en, reg_rw;
    logic [5:0]  reg_addr;
`ifdef ULPI_INIT_SEQ_EN
    logic        init_done, init_err;
`endif

    ulpi_reg_scheduler #(.N_REQ(2), .MAX_RETRY(3), .TIMEOUT(255)) dut (
        .i_clk_60m(clk), .i_rst_usb(rst), .i_req(req), .i_req_rw(req_rw),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_gnt_done(gnt_done), .o_gnt_fail(gnt_fail), .o_rdata(rdata), .o_busy(busy),
        .i_ulpi_ready(ready), .o_reg_en(reg_en), .o_reg_rw(reg_rw), .o_reg_addr(reg_addr),
        .o_reg_data_i(reg_data_i), .i_reg_data_o(reg_data_o), .i_reg_done(reg_done),
`ifdef ULPI_INIT_SEQ_EN
        .o_init_done(init_done), .o_init_err(init_err),
`endif
        .i_reg_fail(reg_fail)
    );

    always #8 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // PHY model configuration (written by the stimulus only)
    int         cfg_lat = 4;
    int         cfg_fails = 0;
    bit         cfg_silent = 1'b0;
    logic [7:0] cfg_rd = 8'h00;

    // Model / monitor state (written by the negedge process only)
    int         phy_cnt = 0, fails_left = 0;
    bit         phy_pend = 1'b0, op_active = 1'b0;
    int         en_cnt = 0, resp_cnt = 0, en_cyc = 0, done_cyc = -1, addr_glitch = 0;
    logic [5:0] en_addr [64];
    logic [7:0] en_data [64];
    logic       en_rw   [64];
    logic [1:0] resp_done [64];
    logic [1:0] resp_fail [64];
    logic [7:0] resp_rdata [64];
    int         resp_cyc [64];

    always @(negedge clk) begin
        reg_done = 1'b0;
        reg_fail = 1'b0;
        if (!busy) op_active = 1'b0;
        if (reg_en) begin
            en_addr[en_cnt & 63] = reg_addr;
            en_data[en_cnt & 63] = reg_data_i;
            en_rw[en_cnt & 63]   = reg_rw;
            en_cnt++;
            en_cyc   = cyc;
            phy_cnt  = cfg_lat;
            phy_pend = 1'b1;
            if (!op_active) begin
                op_active  = 1'b1;
                fails_left = cfg_fails;
            end
        end else if (phy_pend && !cfg_silent) begin
            phy_cnt--;
            if (phy_cnt <= 0) begin
                phy_pend = 1'b0;
                if (fails_left > 0) begin
                    reg_fail = 1'b1;
                    fails_left--;
                end else begin
                    reg_done   = 1'b1;
                    reg_data_o = cfg_rd;
                    done_cyc   = cyc;
                end
            end
        end
        if (busy && en_cnt > 0 && reg_addr != en_addr[(en_cnt - 1) & 63]) addr_glitch++;
        if (gnt_done != 2'b00 || gnt_fail != 2'b00) begin
            resp_done[resp_cnt & 63]  = gnt_done;
            resp_fail[resp_cnt & 63]  = gnt_fail;
            resp_rdata[resp_cnt & 63] = rdata;
            resp_cyc[resp_cnt & 63]   = cyc;
            resp_cnt++;
            phy_pend = 1'b0;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(input int target, input int bound, input string nm);
        int n = 0;
        while (resp_cnt < target && n < bound) begin
            tick(1);
            n++;
        end
        chk({nm, "_arrived"}, 32'(resp_cnt >= target), 32'd1);
    endtask

    // Drive requester `slot` with the given fields; the other slot gets inverted junk.
    task automatic set_fields(input int slot, input logic rw, input logic [5:0] a, input logic [7:0] d);
        for (int s = 0; s < 2; s++) begin
            req_rw[s]          = (s == slot) ? rw : ~rw;
            req_addr[6*s +: 6] = (s == slot) ? a : ~a;
            req_wdata[8*s +: 8] = (s == slot) ? d : ~d;
        end
    endtask

    typedef struct {
        logic [1:0] req;
        logic       rw;
        logic [5:0] addr;
        logic [7:0] wdata;
        logic [7:0] phy_rd;
        int         fails;
        int         lat;
        logic [1:0] exp_done;
        logic [1:0] exp_fail;
        logic [7:0] exp_rdata;
        int         exp_en;
    } vec_t;

    vec_t tv [6];
    int   be, br, r, rst_cyc;

    initial begin
        tv[0] = '{2'b01, 1'b1, 6'h16, 8'hA5, 8'h00, 0, 4, 2'b01, 2'b00, 8'h00, 1};
        tv[1] = '{2'b10, 1'b0, 6'h00, 8'h00, 8'h24, 0, 4, 2'b10, 2'b00, 8'h24, 1};
        tv[2] = '{2'b01, 1'b1, 6'h2A, 8'h3C, 8'h77, 0, 3, 2'b01, 2'b00, 8'h24, 1};
        tv[3] = '{2'b01, 1'b0, 6'h3F, 8'h00, 8'hC3, 3, 2, 2'b01, 2'b00, 8'hC3, 4};
        tv[4] = '{2'b10, 1'b1, 6'h05, 8'h11, 8'h00, 4, 3, 2'b00, 2'b10, 8'hC3, 4};
        tv[5] = '{2'b10, 1'b0, 6'h01, 8'h00, 8'h5A, 1, 1, 2'b10, 2'b00, 8'h5A, 2};

        // Reset state
        tick(3);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_reg_en", 32'(reg_en), 32'd0);
        chk("rst_gnt", 32'({gnt_done, gnt_fail}), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_addr_data", 32'({reg_rw, reg_addr, reg_data_i}), 32'd0);
        rst = 1'b0;
        tick(1);

`ifdef ULPI_INIT_SEQ_EN
        cfg_lat = 2;
        begin
            int n = 0;
            while (!init_done && n < 100) begin tick(1); n++; end
        end
        chk("init_done", 32'(init_done), 32'd1);
        chk("init_err", 32'(init_err), 32'd0);
        chk("init_en_cnt", 32'(en_cnt), 32'd2);
        chk("init_op0", 32'({en_addr[0], en_data[0]}), 32'h0445);
        chk("init_op1", 32'({en_addr[1], en_data[1]}), 32'h0A00);
        chk("init_no_gnt", 32'(resp_cnt), 32'd0);
        tick(3);
`endif

        // Table-driven single ops
        for (int v = 0; v < 6; v++) begin
            be = en_cnt;
            br = resp_cnt;
            cfg_lat   = tv[v].lat;
            cfg_fails = tv[v].fails;
            cfg_rd    = tv[v].phy_rd;
            set_fields(tv[v].req[1] ? 1 : 0, tv[v].rw, tv[v].addr, tv[v].wdata);
            req = tv[v].req;
            wait_resp(br + 1, 200, $sformatf("v%0d", v));
            req = 2'b00;
            r = br & 63;
            chk($sformatf("v%0d_gnt_done", v), 32'(resp_done[r]), 32'(tv[v].exp_done));
            chk($sformatf("v%0d_gnt_fail", v), 32'(resp_fail[r]), 32'(tv[v].exp_fail));
            chk($sformatf("v%0d_rdata", v), 32'(resp_rdata[r]), 32'(tv[v].exp_rdata));
            chk($sformatf("v%0d_issues", v), 32'(en_cnt - be), 32'(tv[v].exp_en));
            chk($sformatf("v%0d_issue_fields", v), 32'({en_rw[be & 63], en_addr[be & 63], en_data[be & 63]}),
                32'({tv[v].rw, tv[v].addr, tv[v].wdata}));
            if (tv[v].exp_done != 2'b00)
                chk($sformatf("v%0d_done_latency", v), 32'(resp_cyc[r] - done_cyc), 32'd1);
            tick(2);
            chk($sformatf("v%0d_no_extra", v), 32'(resp_cnt - br), 32'd1);
        end
        chk("addr_stable", 32'(addr_glitch), 32'd0);

        // Fairness: both held high for four ops
        be = en_cnt;
        br = resp_cnt;
        cfg_lat = 2;
        cfg_fails = 0;
        req_rw = 2'b11;
        req_addr = {6'h20, 6'h10};
        req_wdata = {8'h02, 8'h01};
        req = 2'b11;
        for (int k = 0; k < 4; k++) wait_resp(br + k + 1, 100, $sformatf("rr%0d", k));
        req = 2'b00;
        tick(4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rr%0d_gnt", k), 32'(resp_done[(br + k) & 63]), (k % 2 == 0) ? 32'd1 : 32'd2);
            chk($sformatf("rr%0d_addr", k), 32'(en_addr[(be + k) & 63]), (k % 2 == 0) ? 32'h10 : 32'h20);
        end
        chk("rr_issues", 32'(en_cnt - be), 32'd4);

        // Timeout: PHY never answers
        be = en_cnt;
        br = resp_cnt;
        cfg_silent = 1'b1;
        set_fields(0, 1'b1, 6'h0B, 8'h66);
        req = 2'b01;
        wait_resp(br + 1, 400, "tmo");
        req = 2'b00;
        cfg_silent = 1'b0;
        chk("tmo_fail", 32'({resp_done[br & 63], resp_fail[br & 63]}), 32'h1);
        chk("tmo_cycles", 32'(resp_cyc[br & 63] - en_cyc), 32'd255);
        chk("tmo_issues", 32'(en_cnt - be), 32'd1);
        tick(3);

        // READY low blocks new grants
        be = en_cnt;
        br = resp_cnt;
        cfg_lat = 3;
        ready = 1'b0;
        set_fields(0, 1'b0, 6'h12, 8'h00);
        cfg_rd = 8'h9E;
        req = 2'b01;
        tick(20);
        chk("nrdy_no_issue", 32'(en_cnt - be), 32'd0);
        chk("nrdy_busy", 32'(busy), 32'd0);
        ready = 1'b1;
        wait_resp(br + 1, 50, "nrdy");
        req = 2'b00;
        chk("nrdy_done", 32'({resp_done[br & 63], resp_rdata[br & 63]}), 32'h19E);
        tick(3);

        // Reset mid-op, late REG_DONE must be ignored
        be = en_cnt;
        br = resp_cnt;
        cfg_lat = 10;
        set_fields(0, 1'b1, 6'h33, 8'h44);
        req = 2'b01;
        tick(4);
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        req = 2'b00;
        rst_cyc = cyc;
        tick(1);
        rst = 1'b0;
        tick(15);
        chk("mid_late_done_seen", 32'(done_cyc > rst_cyc), 32'd1);
        chk("mid_no_resp", 32'(resp_cnt - br), 32'd0);
        chk("mid_idle", 32'({busy, reg_en}), 32'd0);
        chk("mid_issues", 32'(en_cnt - be), 32'd1);

`ifndef ULPI_INIT_SEQ_EN
        // Operation after reset still works
        br = resp_cnt;
        cfg_lat = 2;
        cfg_rd = 8'h3D;
        set_fields(1, 1'b0, 6'h07, 8'h00);
        req = 2'b10;
        wait_resp(br + 1, 50, "post_rst");
        req = 2'b00;
        chk("post_rst_done", 32'({resp_done[br & 63], resp_rdata[br & 63]}), 32'h23D);
        tick(2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
